onchip_memory_dualport: RTL and testbench

Parametrised true-dual-port on-chip RAM with two independent Avalon-MM slaves (s1, s2) on one clock. It adds four things: a configurable pipelined read latency with `readdatavalid`, per-port byte enables, defined write-collision arbitration, and an optional hardware zero-fill sequencer that runs after reset. It sits on the SOPC interconnect as general-purpose data memory shared by the CPU (s1) and a DMA/streaming master (s2).

---
 rtl/onchip_memory_dualport_if.sv | 25 ++
 rtl/onchip_memory_dualport.sv | 145 ++++++++++++++
 tb/tb_onchip_memory_dualport.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/onchip_memory_dualport_if.sv
// One Avalon-MM slave port of the dual-port RAM. Each of s1 and s2 is a
// separate instance of this interface.
interface onchip_memory_dualport_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
);
  logic [ADDR_WIDTH-1:0]   address;
  logic [DATA_WIDTH/8-1:0] byteenable;
  logic                    chipselect;
  logic                    read;
  logic                    write;
  logic [DATA_WIDTH-1:0]   writedata;
  logic [DATA_WIDTH-1:0]   readdata;
  logic                    readdatavalid;
  logic                    waitrequest;

  modport master (
    output address, byteenable, chipselect, read, write, writedata,
    input  readdata, readdatavalid, waitrequest
  );
  modport slave (
    input  address, byteenable, chipselect, read, write, writedata,
    output readdata, readdatavalid, waitrequest
  );
endinterface

// File: rtl/onchip_memory_dualport.sv
// True dual-port RAM with two Avalon-MM slaves on one clock. It has pipelined
// reads, byte-lane writes, s1-priority collision handling and a zero-fill after reset.
//
//   state   | meaning
//   S_CLEAR | sweeping zeros through the RAM, both ports held off
//   S_RUN   | normal operation, transfers accepted whenever clken is high
module onchip_memory_dualport #(
  parameter int DATA_WIDTH     = 16,
  parameter int ADDR_WIDTH     = 10,
  parameter int DEPTH          = 1024,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clken,
  output logic                     clear_busy,
  onchip_memory_dualport_if.slave  s1,
  onchip_memory_dualport_if.slave  s2
);
  localparam int                    NB      = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_C  = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {S_CLEAR, S_RUN} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  clr_we;
  logic                  stall;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] addr  [2];
  logic [NB-1:0]         be    [2];
  logic [DATA_WIDTH-1:0] wdata [2];
  logic [DATA_WIDTH-1:0] rdata [2];
  logic [1:0]            cs, rd, wr, rvalid, in_rng, rd_go, wr_go;

  assign addr[0]  = s1.address;    assign addr[1]  = s2.address;
  assign be[0]    = s1.byteenable; assign be[1]    = s2.byteenable;
  assign wdata[0] = s1.writedata;  assign wdata[1] = s2.writedata;
  assign cs       = {s2.chipselect, s1.chipselect};
  assign rd       = {s2.read, s1.read};
  assign wr       = {s2.write, s1.write};

  assign stall            = (state_q == S_CLEAR) | ~clken;
  assign clear_busy       = (state_q == S_CLEAR);
  assign s1.waitrequest   = stall;
  assign s2.waitrequest   = stall;
  assign s1.readdata      = rdata[0];
  assign s2.readdata      = rdata[1];
  assign s1.readdatavalid = rvalid[0];
  assign s2.readdatavalid = rvalid[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_we  = 1'b0;
    case (state_q)
      S_CLEAR: begin
        if (clken) begin
          clr_we = 1'b1;
          if (cnt_q == LAST_C) begin
            state_d = S_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + ADDR_WIDTH'(1);
          end
        end
      end
      default: ;
    endcase
  end

  // s1 is written last so it owns every lane it enables on a same-address collision.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[cnt_q] <= '0;
    end else begin
      for (int b = 0; b < NB; b++) begin
        if (wr_go[1] && be[1][b]) mem[addr[1]][b*8 +: 8] <= wdata[1][b*8 +: 8];
        if (wr_go[0] && be[0][b]) mem[addr[0]][b*8 +: 8] <= wdata[0][b*8 +: 8];
      end
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [DATA_WIDTH-1:0] word;

    assign in_rng[p] = ({1'b0, addr[p]} < DEPTH_C);
    assign rd_go[p]  = cs[p] & rd[p] & ~wr[p] & ~stall;
    assign wr_go[p]  = cs[p] & wr[p] & ~stall & in_rng[p];
    // Sampled before the edge's write lands, so read-during-write returns old data.
    assign word      = in_rng[p] ? mem[addr[p]] : '0;

    if (READ_LATENCY == 2) begin : g_lat2
      logic [DATA_WIDTH-1:0] stg_q, out_q;
      logic                  stg_vld_q, vld_q;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          stg_q     <= '0;
          stg_vld_q <= 1'b0;
          out_q     <= '0;
          vld_q     <= 1'b0;
        end else if (clken) begin
          stg_vld_q <= rd_go[p];
          if (rd_go[p]) stg_q <= word;
          vld_q     <= stg_vld_q;
          if (stg_vld_q) out_q <= stg_q;
        end
      end

      assign rdata[p]  = out_q;
      assign rvalid[p] = vld_q;
    end else begin : g_lat1
      logic [DATA_WIDTH-1:0] out_q;
      logic                  vld_q;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          out_q <= '0;
          vld_q <= 1'b0;
        end else if (clken) begin
          vld_q <= rd_go[p];
          if (rd_go[p]) out_q <= word;
        end
      end

      assign rdata[p]  = out_q;
      assign rvalid[p] = vld_q;
    end
  end
endmodule

// File: tb/tb_onchip_memory_dualport.sv
// Drives two RAM configurations with identical traffic: A (DEPTH 1024, latency 2)
// and B (DEPTH 1000, latency 1). Both are checked against a transaction-level model.
module tb_onchip_memory_dualport;
  logic clk, reset_n, clken;
  logic busy_a, busy_b;

  logic [9:0]  t_addr [2];
  logic [1:0]  t_be   [2];
  logic        t_cs   [2], t_rd [2], t_wr [2];
  logic [15:0] t_wd   [2];

  onchip_memory_dualport_if #(.DATA_WIDTH(16), .ADDR_WIDTH(10)) a1(), a2(), b1(), b2();

  onchip_memory_dualport #(.DATA_WIDTH(16), .ADDR_WIDTH(10), .DEPTH(1024),
                           .READ_LATENCY(2), .CLEAR_ON_RESET(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .clken(clken), .clear_busy(busy_a), .s1(a1), .s2(a2));
  onchip_memory_dualport #(.DATA_WIDTH(16), .ADDR_WIDTH(10), .DEPTH(1000),
                           .READ_LATENCY(1), .CLEAR_ON_RESET(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .clken(clken), .clear_busy(busy_b), .s1(b1), .s2(b2));

  assign a1.address = t_addr[0]; assign a1.byteenable = t_be[0]; assign a1.chipselect = t_cs[0];
  assign a1.read = t_rd[0]; assign a1.write = t_wr[0]; assign a1.writedata = t_wd[0];
  assign b1.address = t_addr[0]; assign b1.byteenable = t_be[0]; assign b1.chipselect = t_cs[0];
  assign b1.read = t_rd[0]; assign b1.write = t_wr[0]; assign b1.writedata = t_wd[0];
  assign a2.address = t_addr[1]; assign a2.byteenable = t_be[1]; assign a2.chipselect = t_cs[1];
  assign a2.read = t_rd[1]; assign a2.write = t_wr[1]; assign a2.writedata = t_wd[1];
  assign b2.address = t_addr[1]; assign b2.byteenable = t_be[1]; assign b2.chipselect = t_cs[1];
  assign b2.read = t_rd[1]; assign b2.write = t_wr[1]; assign b2.writedata = t_wd[1];

  // Port index k: 0 = A.s1, 1 = A.s2, 2 = B.s1, 3 = B.s2
  logic        dv [4], dw [4], bz [2];
  logic [15:0] dd [4];
  assign dv[0] = a1.readdatavalid; assign dv[1] = a2.readdatavalid;
  assign dv[2] = b1.readdatavalid; assign dv[3] = b2.readdatavalid;
  assign dd[0] = a1.readdata; assign dd[1] = a2.readdata;
  assign dd[2] = b1.readdata; assign dd[3] = b2.readdata;
  assign dw[0] = a1.waitrequest; assign dw[1] = a2.waitrequest;
  assign dw[2] = b1.waitrequest; assign dw[3] = b2.waitrequest;
  assign bz[0] = busy_a; assign bz[1] = busy_b;

  string pn [4] = '{"A.s1", "A.s2", "B.s1", "B.s2"};
  string iname [2] = '{"A", "B"};
  int    dep [2] = '{1024, 1000};
  int    lat [2] = '{2, 1};

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h at %0t", nm, act, exp, $time);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Transaction-level model: per-instance memory image, clear progress and
  // per-port queues of read results tagged with the enabled cycle they are due.
  logic [15:0] mm   [2][1024];
  int          clr  [2] = '{0, 0};
  logic [15:0] pd   [4][16];
  int          pdue [4][16];
  int          ph   [4] = '{0, 0, 0, 0};
  int          pt   [4] = '{0, 0, 0, 0};
  logic [15:0] m_rd [4] = '{16'h0, 16'h0, 16'h0, 16'h0};
  logic        m_rv [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
  int          ecnt = 0;

  initial begin
    int          k;
    logic [15:0] w;
    for (int i = 0; i < 2; i++)
      for (int a = 0; a < 1024; a++) mm[i][a] = 16'h0;
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        for (int j = 0; j < 4; j++) begin
          ph[j] = 0; pt[j] = 0; m_rd[j] = 16'h0; m_rv[j] = 1'b0;
        end
        clr[0] = 0; clr[1] = 0;
      end else if (clken) begin
        ecnt++;
        for (int i = 0; i < 2; i++) begin
          if (clr[i] < dep[i]) begin
            mm[i][clr[i]] = 16'h0;
            clr[i]++;
          end else begin
            for (int p = 0; p < 2; p++) begin
              k = 2*i + p;
              if (t_cs[p] && t_rd[p] && !t_wr[p]) begin
                pd[k][pt[k] % 16]   = (int'(t_addr[p]) < dep[i]) ? mm[i][t_addr[p]] : 16'h0;
                pdue[k][pt[k] % 16] = ecnt + lat[i] - 1;
                pt[k]++;
              end
            end
            for (int p = 0; p < 2; p++) begin
              if (t_cs[p] && t_wr[p] && int'(t_addr[p]) < dep[i]) begin
                w = mm[i][t_addr[p]];
                for (int b = 0; b < 2; b++)
                  if (t_be[p][b] && !(p == 1 && t_cs[0] && t_wr[0] &&
                                      t_addr[0] == t_addr[1] && t_be[0][b]))
                    w[b*8 +: 8] = t_wd[p][b*8 +: 8];
                mm[i][t_addr[p]] = w;
              end
            end
          end
          for (int p = 0; p < 2; p++) begin
            k = 2*i + p;
            if (ph[k] != pt[k] && pdue[k][ph[k] % 16] == ecnt) begin
              m_rv[k] = 1'b1;
              m_rd[k] = pd[k][ph[k] % 16];
              ph[k]++;
            end else begin
              m_rv[k] = 1'b0;
            end
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        check({iname[i], " clear_busy"}, 32'(bz[i]), 32'(clr[i] < dep[i]));
        for (int p = 0; p < 2; p++) begin
          check({pn[2*i+p], " waitrequest"}, 32'(dw[2*i+p]),
                32'((clr[i] < dep[i]) || !clken));
          check({pn[2*i+p], " readdatavalid"}, 32'(dv[2*i+p]), 32'(m_rv[2*i+p]));
          check({pn[2*i+p], " readdata"}, 32'(dd[2*i+p]), 32'(m_rd[2*i+p]));
        end
      end
    end
  end

  task automatic set(input int p, input logic c, input logic r, input logic w,
                     input logic [9:0] a, input logic [15:0] d, input logic [1:0] b);
    t_cs[p] = c; t_rd[p] = r; t_wr[p] = w; t_addr[p] = a; t_wd[p] = d; t_be[p] = b;
  endtask

  task automatic idle();
    for (int p = 0; p < 2; p++) begin
      t_cs[p] = 1'b0; t_rd[p] = 1'b0; t_wr[p] = 1'b0;
    end
  endtask

  task automatic do_write(input int p, input logic [9:0] a, input logic [15:0] d,
                          input logic [1:0] b);
    set(p, 1'b1, 1'b0, 1'b1, a, d, b);
    @(negedge clk);
    idle();
  endtask

  task automatic do_read(input int p, input logic [9:0] a, input logic [15:0] ea,
                         input logic [15:0] eb, input string nm);
    int ca, cb;
    ca = 0; cb = 0;
    set(p, 1'b1, 1'b1, 1'b0, a, 16'h0, 2'b11);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) idle();
      if (ca == 0 && dv[p]) begin ca = c; check({nm, " A data"}, 32'(dd[p]), 32'(ea)); end
      if (cb == 0 && dv[2+p]) begin cb = c; check({nm, " B data"}, 32'(dd[2+p]), 32'(eb)); end
    end
    check({nm, " A latency"}, ca, 2);
    check({nm, " B latency"}, cb, 1);
  endtask

  task automatic count_busy(input string nm, input int ea, input int eb);
    int na, nb;
    na = 0; nb = 0;
    for (int c = 0; c < 1200; c++) begin
      if (!bz[0] && !bz[1]) break;
      if (bz[0]) na++;
      if (bz[1]) nb++;
      @(negedge clk);
    end
    check({nm, " A busy cycles"}, na, ea);
    check({nm, " B busy cycles"}, nb, eb);
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int fa, ha, hb;
    reset_n = 1'b0;
    clken   = 1'b1;
    for (int p = 0; p < 2; p++) set(p, 1'b0, 1'b0, 1'b0, 10'd0, 16'h0, 2'b00);
    repeat (3) @(negedge clk);
    check("reset A clear_busy", 32'(bz[0]), 1);
    check("reset A.s1 waitrequest", 32'(dw[0]), 1);
    check("reset B.s2 readdatavalid", 32'(dv[3]), 0);
    check("reset A.s2 readdata", 32'(dd[1]), 0);
    reset_n = 1'b1;
    count_busy("initial clear", 1024, 1000);

    do_write(0, 10'd0, 16'hFFFF, 2'b11);
    do_write(0, 10'd511, 16'hFFFF, 2'b11);
    do_write(1, 10'd1023, 16'hFFFF, 2'b11);
    do_read(0, 10'd0, 16'hFFFF, 16'hFFFF, "preload 0");
    do_read(1, 10'd511, 16'hFFFF, 16'hFFFF, "preload 511");
    do_read(0, 10'd1023, 16'hFFFF, 16'h0000, "preload 1023");

    pulse_reset();
    repeat (300) @(negedge clk);
    pulse_reset();
    count_busy("restarted clear", 1024, 1000);
    do_read(0, 10'd0, 16'h0000, 16'h0000, "cleared 0");
    do_read(1, 10'd511, 16'h0000, 16'h0000, "cleared 511");
    do_read(0, 10'd1023, 16'h0000, 16'h0000, "cleared 1023");

    do_write(0, 10'd5, 16'h1234, 2'b11);
    do_write(0, 10'd6, 16'hABCD, 2'b11);
    set(1, 1'b1, 1'b1, 1'b0, 10'd5, 16'h0, 2'b11);
    @(negedge clk);
    set(1, 1'b1, 1'b1, 1'b0, 10'd6, 16'h0, 2'b11);
    check("pipe N+1 A valid", 32'(dv[1]), 0);
    check("pipe N+1 B valid", 32'(dv[3]), 1);
    check("pipe N+1 B data", 32'(dd[3]), 32'h1234);
    @(negedge clk);
    idle();
    check("pipe N+2 A valid", 32'(dv[1]), 1);
    check("pipe N+2 A data", 32'(dd[1]), 32'h1234);
    check("pipe N+2 model A data", 32'(m_rd[1]), 32'h1234);
    check("pipe N+2 B data", 32'(dd[3]), 32'hABCD);
    @(negedge clk);
    check("pipe N+3 A valid", 32'(dv[1]), 1);
    check("pipe N+3 A data", 32'(dd[1]), 32'hABCD);
    check("pipe N+3 model A data", 32'(m_rd[1]), 32'hABCD);
    check("pipe N+3 B valid", 32'(dv[3]), 0);
    @(negedge clk);
    check("pipe N+4 A valid", 32'(dv[1]), 0);
    check("pipe N+4 A data hold", 32'(dd[1]), 32'hABCD);

    do_write(1, 10'd3, 16'hAAAA, 2'b11);
    do_write(1, 10'd3, 16'h5511, 2'b01);
    do_read(0, 10'd3, 16'hAA11, 16'hAA11, "byteenable");

    set(0, 1'b1, 1'b0, 1'b1, 10'd7, 16'h1111, 2'b10);
    set(1, 1'b1, 1'b0, 1'b1, 10'd7, 16'h2222, 2'b11);
    @(negedge clk);
    idle();
    do_read(0, 10'd7, 16'h1122, 16'h1122, "collision");

    do_write(0, 10'd9, 16'h0009, 2'b11);
    set(0, 1'b1, 1'b0, 1'b1, 10'd9, 16'h9999, 2'b11);
    do_read(1, 10'd9, 16'h0009, 16'h0009, "rdw old");
    do_read(1, 10'd9, 16'h9999, 16'h9999, "rdw new");

    do_write(1, 10'd1023, 16'hBEEF, 2'b11);
    do_read(1, 10'd1023, 16'hBEEF, 16'h0000, "out of range");

    fa = 0; ha = 0; hb = 0;
    set(0, 1'b1, 1'b1, 1'b0, 10'd5, 16'h0, 2'b11);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) begin idle(); clken = 1'b0; end
      if (c == 4) clken = 1'b1;
      if (dv[0]) begin ha++; if (fa == 0) fa = c; end
      if (dv[2]) hb++;
    end
    check("clken A valid delay", fa, 5);
    check("clken A valid width", ha, 1);
    check("clken A data", 32'(dd[0]), 32'h1234);
    check("clken B valid held", hb, 4);

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
